// File: rtl/x9_seq_pkg.sv
// Shared types and opcode constants for the X9 multi-cycle sequencer.
package x9_seq_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        EXEC   = 4'd3,
        MEM    = 4'd4,
        WB     = 4'd5,
        PCUP   = 4'd6,
        HALT   = 4'd7,
        ERR    = 4'd8
    } state_t;

    localparam logic [4:0] OP_BEQ = 5'b00101;
    localparam logic [4:0] OP_BNE = 5'b00110;
    localparam logic [4:0] OP_EQ  = 5'b01101;
    localparam logic [4:0] OP_LT  = 5'b01110;

endpackage

// File: rtl/x9_wait_timer.sv
// MEM-state wait counter: cleared outside MEM, counts cycles without mem_ready,
// and flags when the count sits at TIMEOUT-1.
module x9_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expired = (cnt_q == W'(TIMEOUT - 1));

    // next count: hold at the terminal value so it never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/x9_sequencer.sv
// X9 multi-cycle sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB/PCUP and drives the datapath enables.
//
//   state  | meaning
//   IDLE   | waiting for start
//   FETCH  | load instruction register
//   DECODE | latch decoder controls and opcode
//   EXEC   | ALU cycle, compares update cond_flag
//   MEM    | data memory request, waits for mem_ready
//   WB     | register-file write
//   PCUP   | PC update, retire instruction
//   HALT   | program done, waiting for start to fall
//   ERR    | memory timeout, held until reset
module x9_sequencer
    import x9_seq_pkg::*;
#(
    parameter int OPW         = 5,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             last_instr,
    input  logic [OPW-1:0]   opcode,
    input  logic             branch_inst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             reg_write,
    input  logic             alu_flag,
    input  logic             mem_ready,
    output logic             ir_load,
    output logic             alu_en,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_we,
    output logic             pc_en,
    output logic             branch_take,
    output logic             cond_flag,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q, state_d;
    logic [OPW-1:0]   opcode_l_q, opcode_l_d;
    logic             branch_l_q, branch_l_d;
    logic             rd_l_q, rd_l_d;
    logic             w_l_q, w_l_d;
    logic             reg_write_l_q, reg_write_l_d;
    logic             last_l_q, last_l_d;
    logic             cond_q, cond_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic ir_load_q, ir_load_d;
    logic alu_en_q, alu_en_d;
    logic mem_req_q, mem_req_d;
    logic reg_we_q, reg_we_d;
    logic pc_en_q, pc_en_d;
    logic branch_take_q, branch_take_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;

    logic timer_expired;

    x9_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != MEM),
        .enable  ((state_q == MEM) && !mem_ready),
        .expired (timer_expired)
    );

    // next state, latched controls, flag/counter updates and next outputs
    always_comb begin
        state_d       = state_q;
        opcode_l_d    = opcode_l_q;
        branch_l_d    = branch_l_q;
        rd_l_d        = rd_l_q;
        w_l_d         = w_l_q;
        reg_write_l_d = reg_write_l_q;
        last_l_d      = last_l_q;
        cond_d        = cond_q;
        retired_d     = retired_q;

        unique case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                state_d = DECODE;
            end
            DECODE: begin
                opcode_l_d    = opcode;
                branch_l_d    = branch_inst;
                rd_l_d        = mem_read;
                w_l_d         = mem_write;
                reg_write_l_d = reg_write;
                last_l_d      = last_instr;
                state_d       = EXEC;
            end
            EXEC: begin
                if ((opcode_l_q == OPW'(OP_EQ)) || (opcode_l_q == OPW'(OP_LT))) begin
                    cond_d = alu_flag;
                end
                if (rd_l_q || w_l_q) begin
                    state_d = MEM;
                end else if (reg_write_l_q) begin
                    state_d = WB;
                end else begin
                    state_d = PCUP;
                end
            end
            MEM: begin
                // a completing access beats a timeout landing in the same cycle
                if (mem_ready) begin
                    state_d = rd_l_q ? WB : PCUP;
                end else if (timer_expired) begin
                    state_d = ERR;
                end
            end
            WB: begin
                state_d = PCUP;
            end
            PCUP: begin
                if (retired_q != '1) retired_d = retired_q + 1'b1;
                state_d = last_l_q ? HALT : FETCH;
            end
            HALT: begin
                if (!start) state_d = IDLE;
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // outputs are registered from the next state so they line up with it
        ir_load_d     = (state_d == FETCH);
        alu_en_d      = (state_d == EXEC);
        mem_req_d     = (state_d == MEM);
        reg_we_d      = (state_d == WB);
        pc_en_d       = (state_d == PCUP);
        branch_take_d = (state_d == PCUP) && branch_l_d &&
                        ((opcode_l_d == OPW'(OP_BEQ)) ? cond_d : !cond_d);
        busy_d        = !((state_d == IDLE) || (state_d == HALT) || (state_d == ERR));
        done_d        = (state_d == HALT);
        err_d         = (state_d == ERR);
    end

    // single state/output register bank
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            opcode_l_q    <= '0;
            branch_l_q    <= 1'b0;
            rd_l_q        <= 1'b0;
            w_l_q         <= 1'b0;
            reg_write_l_q <= 1'b0;
            last_l_q      <= 1'b0;
            cond_q        <= 1'b0;
            retired_q     <= '0;
            ir_load_q     <= 1'b0;
            alu_en_q      <= 1'b0;
            mem_req_q     <= 1'b0;
            reg_we_q      <= 1'b0;
            pc_en_q       <= 1'b0;
            branch_take_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            opcode_l_q    <= opcode_l_d;
            branch_l_q    <= branch_l_d;
            rd_l_q        <= rd_l_d;
            w_l_q         <= w_l_d;
            reg_write_l_q <= reg_write_l_d;
            last_l_q      <= last_l_d;
            cond_q        <= cond_d;
            retired_q     <= retired_d;
            ir_load_q     <= ir_load_d;
            alu_en_q      <= alu_en_d;
            mem_req_q     <= mem_req_d;
            reg_we_q      <= reg_we_d;
            pc_en_q       <= pc_en_d;
            branch_take_q <= branch_take_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign ir_load     = ir_load_q;
    assign alu_en      = alu_en_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_req_q & w_l_q;
    assign reg_we      = reg_we_q;
    assign pc_en       = pc_en_q;
    assign branch_take = branch_take_q;
    assign cond_flag   = cond_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_x9_sequencer.sv
// Self-checking bench for x9_sequencer: builds an expected per-cycle trace
// from instruction-level rules, then replays the stimulus and compares.
module tb_x9_sequencer;

    localparam int TO = 4;
    localparam int CW = 2;
    localparam logic [4:0] BEQ = 5'b00101;
    localparam logic [4:0] BNE = 5'b00110;
    localparam logic [4:0] EQ  = 5'b01101;
    localparam logic [4:0] LT  = 5'b01110;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, last_instr, branch_inst, mem_read, mem_write, reg_write;
    logic          alu_flag, mem_ready;
    logic [4:0]    opcode;
    logic          ir_load, alu_en, mem_req, mem_we, reg_we, pc_en, branch_take;
    logic          cond_flag, busy, done, err;
    logic [CW-1:0] retired;

    x9_sequencer #(.OPW(5), .CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .last_instr(last_instr),
        .opcode(opcode), .branch_inst(branch_inst), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .alu_flag(alu_flag),
        .mem_ready(mem_ready), .ir_load(ir_load), .alu_en(alu_en),
        .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we), .pc_en(pc_en),
        .branch_take(branch_take), .cond_flag(cond_flag), .busy(busy),
        .done(done), .err(err), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic ir, alu, req, we, rwe, pc, bt, cf, bsy, dn, er;
        logic [CW-1:0] ret;
    } out_t;

    typedef struct packed {
        logic rst, start, last;
        logic [4:0] op;
        logic br, mr, mw, rw, af, rdy;
    } in_t;

    in_t  in_q[$];
    out_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   idx = 0;
    logic run = 1'b0;
    logic          m_cond;
    logic [CW-1:0] m_ret;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, got, want);
        end
    endtask

    function automatic out_t base();
        out_t o;
        o = '0;
        o.cf = m_cond;
        o.ret = m_ret;
        return o;
    endfunction

    function automatic in_t rnd_in();
        in_t i;
        logic [31:0] r;
        r = $urandom;
        i = r[13:0];
        i.rst = 1'b0;
        return i;
    endfunction

    function automatic out_t sample();
        out_t a;
        a = {ir_load, alu_en, mem_req, mem_we, reg_we, pc_en, branch_take,
             cond_flag, busy, done, err, retired};
        return a;
    endfunction

    task automatic push(input in_t i, input out_t o);
        in_q.push_back(i);
        exp_q.push_back(o);
    endtask

    task automatic gen_start(input int idle_n);
        in_t i;
        for (int n = 0; n < idle_n; n++) begin
            i = rnd_in(); i.start = 1'b0; push(i, base());
        end
        i = rnd_in(); i.start = 1'b1; push(i, base());
    endtask

    // kinds: 0 add, 1 eq, 2 lt, 3 beq, 4 bne, 5 lb, 6 sb, 7 random fields
    // k: MEM cycle (0-based) with mem_ready; k >= TO means never ready
    task automatic gen_instr(input int kind, input int k, input logic af,
                             input int abort_at, input logic last,
                             output int ncyc, output logic bt, output logic ended);
        in_t i; out_t o; logic [31:0] r;
        logic [4:0] op; logic br, mr, mw, rw, wb;
        r = $urandom;
        br = 0; mr = 0; mw = 0; rw = 0;
        case (kind)
            0: begin op = {3'b000, r[1:0]} ^ 5'b00100; rw = 1; end
            1: op = EQ;
            2: op = LT;
            3: begin op = BEQ; br = 1; end
            4: begin op = BNE; br = 1; end
            5: begin op = 5'b00011; mr = 1; rw = 1; end
            6: begin op = 5'b00111; mw = 1; end
            default: begin op = r[4:0]; br = r[5]; mr = r[6]; mw = r[7]; rw = r[8]; end
        endcase
        ncyc = 0; bt = 0; ended = 0;
        i = rnd_in(); o = base(); o.ir = 1; o.bsy = 1; push(i, o); ncyc++;
        i = rnd_in(); i.op = op; i.br = br; i.mr = mr; i.mw = mw; i.rw = rw; i.last = last;
        o = base(); o.bsy = 1; push(i, o); ncyc++;
        i = rnd_in(); i.af = af; o = base(); o.alu = 1; o.bsy = 1; push(i, o); ncyc++;
        if (op == EQ || op == LT) m_cond = af;
        if (mr | mw) begin
            for (int c = 0; c < TO; c++) begin
                i = rnd_in(); i.rdy = (c == k);
                o = base(); o.req = 1; o.we = mw; o.bsy = 1;
                if (c == abort_at) begin
                    i.rst = 1; push(i, o); ncyc++;
                    m_cond = 0; m_ret = '0; ended = 1;
                    return;
                end
                push(i, o); ncyc++;
                if (c == k) break;
            end
            if (k >= TO) begin
                for (int n = 0; n < 3; n++) begin
                    i = rnd_in(); o = base(); o.er = 1; push(i, o);
                end
                i = rnd_in(); i.rst = 1; o = base(); o.er = 1; push(i, o);
                m_cond = 0; m_ret = '0; ended = 1;
                return;
            end
            wb = mr;
        end else begin
            wb = rw;
        end
        if (wb) begin
            i = rnd_in(); o = base(); o.rwe = 1; o.bsy = 1; push(i, o); ncyc++;
        end
        bt = br & ((op == BEQ) ? m_cond : ~m_cond);
        i = rnd_in(); o = base(); o.pc = 1; o.bt = bt; o.bsy = 1; push(i, o); ncyc++;
        if (m_ret != '1) m_ret = m_ret + 1'b1;
        if (last) begin
            for (int n = 0; n < int'($urandom_range(0, 2)); n++) begin
                i = rnd_in(); i.start = 1; o = base(); o.dn = 1; push(i, o);
            end
            i = rnd_in(); i.start = 0; o = base(); o.dn = 1; push(i, o);
        end
    endtask

    // one compare process: DUT outputs against the planned trace
    always @(negedge clk) begin
        if (run) chk($sformatf("cycle%0d", idx), 32'(sample()), 32'(exp_q[idx]));
    end

    initial begin
        int n; logic bt, e;
        int nins, kind, kk, ab;
        in_t i;

        m_cond = 0; m_ret = '0;
        gen_start(2);
        gen_instr(0, 0, 0, -1, 1, n, bt, e);
        chk("pin_add_len", n, 5);
        chk("pin_add_ret", 32'(m_ret), 1);

        gen_start(1);
        gen_instr(1, 0, 1, -1, 0, n, bt, e);
        chk("pin_eq_len", n, 4);
        chk("pin_eq_cond", 32'(m_cond), 1);
        gen_instr(3, 0, 0, -1, 0, n, bt, e);
        chk("pin_beq_len", n, 4);
        chk("pin_beq_take", 32'(bt), 1);
        gen_instr(1, 0, 1, -1, 0, n, bt, e);
        gen_instr(4, 0, 0, -1, 1, n, bt, e);
        chk("pin_bne_take", 32'(bt), 0);

        gen_start(0);
        gen_instr(5, 2, 0, -1, 0, n, bt, e);
        chk("pin_lb_len", n, 8);
        gen_instr(6, 0, 0, -1, 1, n, bt, e);
        chk("pin_sb_len", n, 5);

        gen_start(1);
        gen_instr(6, TO, 0, -1, 0, n, bt, e);
        chk("pin_timeout_req", n - 3, 4);
        chk("pin_timeout_end", 32'(e), 1);

        gen_start(0);
        gen_instr(1, 0, 1, -1, 0, n, bt, e);
        gen_instr(5, 3, 0, 1, 0, n, bt, e);
        chk("pin_abort_cond", 32'(m_cond), 0);

        gen_start(0);
        for (int q = 0; q < 5; q++) gen_instr(0, 0, 0, -1, q == 4, n, bt, e);
        chk("pin_sat_ret", 32'(m_ret), 3);

        for (int p = 0; p < 40; p++) begin
            gen_start(int'($urandom_range(0, 2)));
            nins = int'($urandom_range(1, 6));
            for (int q = 0; q < nins; q++) begin
                kind = int'($urandom_range(0, 7));
                kk   = int'($urandom_range(0, TO));
                ab   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, TO - 1)) : -1;
                gen_instr(kind, kk, 1'($urandom), ab, q == nins - 1, n, bt, e);
                if (e) break;
            end
        end

        // reset with busy inputs, including start held high
        reset = 1; start = 1; last_instr = 1; opcode = EQ; branch_inst = 1;
        mem_read = 1; mem_write = 1; reg_write = 1; alu_flag = 1; mem_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 32'(sample()), 0);

        for (int j = 0; j < in_q.size(); j++) begin
            i = in_q[j];
            reset = i.rst; start = i.start; last_instr = i.last; opcode = i.op;
            branch_inst = i.br; mem_read = i.mr; mem_write = i.mw; reg_write = i.rw;
            alu_flag = i.af; mem_ready = i.rdy;
            idx = j;
            run = 1'b1;
            @(posedge clk);
            #1;
        end
        run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
